run_detect_ctrl: RTL and testbench
==================================

Name: run_detect_ctrl

Overview:
Sequencing controller for the serial equal-bit run detector used on the single-bit `w` stream. Software or upstream logic arms it with a run length and a polarity mode. It then scans a bounded window of valid bits, flags qualifying runs on `s` and counts them. It ends the scan on window completion, abort, or input-starvation timeout, and reports status.

Parameters:
WINDOW, 64, number of accepted bits per scan (2..65535)
TIMEOUT, 32, max consecutive cycles without w_valid while scanning (1..65535)
CNT_W, 8, width of match_cnt

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  begin scan; honoured only in IDLE
abort  in  1  terminate scan; honoured only in RUN
cfg_len  in  4  required run length; values 0 and 1 are treated as 2
cfg_mode  in  2  01 = zero-runs, 10 = one-runs, 11 = both, 00 = both
w_valid  in  1  w carries a bit this cycle
w  in  1  serial data bit
s  out  1  registered run flag
busy  out  1  high in RUN
done  out  1  one-cycle completion pulse
timed_out  out  1  last scan ended by timeout
aborted  out  1  last scan ended by abort
match_cnt  out  CNT_W  qualifying runs in last/current scan, saturating

Behaviour:
- Reset: the reset input is synchronous and active-high. State is IDLE, and all outputs plus internal counters are 0.
- States: IDLE, RUN, DONE.
- IDLE
  - start=1: latch cfg_len (after the 0/1→2 clamp) and cfg_mode.
  - Clear run_cnt, bit_cnt, idle_cnt, match_cnt, timed_out and aborted.
  - Next state is RUN; busy=1 from the next cycle.
- RUN, evaluated in priority order:
  1. abort=1 → aborted=1 and go to DONE. Any w_valid in the same cycle is discarded and not counted.
  2. w_valid=1:
     - bit_cnt+1 and idle_cnt=0.
     - If run_cnt==0 or w==last_bit, then run_cnt=min(run_cnt+1,15); otherwise run_cnt=1.
     - last_bit=w.
  3. w_valid=0: idle_cnt+1. When idle_cnt reaches TIMEOUT, set timed_out=1 and go to DONE.
- s update: s updates on every accepted bit, in the cycle after that bit.
  - s=1 iff the new run_cnt ≥ len and polarity w is enabled by the mode.
  - s holds its value between valid bits.
- Match counting: match_cnt increments once per run, when the new run_cnt == len exactly and polarity is enabled. It saturates at all-ones.
- Window end: the accepted bit that makes bit_cnt==WINDOW is fully processed (s and match_cnt update), then the FSM goes to DONE.
- DONE
  - Lasts one cycle with done=1, busy=0 and s=0.
  - Next state is IDLE. start is ignored in DONE.
- Held status: match_cnt, timed_out and aborted hold until the next start.
- Ignored inputs: start during RUN has no effect. abort in IDLE or DONE has no effect.
- Reset during RUN: immediate return to IDLE with all outputs 0; no done pulse.

Test Plan:
- Reset, then start with cfg_len=4, mode=11. Feed 1,1,1,1,0,0,0,0 on consecutive valid cycles. Required: s rises the cycle after bit 4, drops after bit 5, and rises again after bit 8; match_cnt=2.
- len=4, mode=01. Feed 1×6 then 0×5. Required: s stays 0 through the ones, rises after the 4th zero and stays high for the 5th; match_cnt=1.
- WINDOW=8, alternating 0/1 for 8 bits. Required: done pulses exactly one cycle after bit 8 is processed, busy falls with it, match_cnt=0, timed_out=0.
- TIMEOUT=32. Start, send 2 bits, then hold w_valid=0. Required: timed_out=1 and done pulses when idle_cnt reaches 32; no further state change after that.
- Assert abort in the same cycle as w_valid during a 3-bit run of ones with len=3. Required: the bit is discarded, match_cnt is unchanged, and done and aborted are both set.
- cfg_len=0 behaves as 2. start while busy is ignored. Reset mid-scan: outputs are 0 next cycle and no done pulse.

Source files
------------

// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: arms on start, scans a bounded window of valid bits on w,
// flags equal-bit runs of at least the configured length on s and counts
// each qualifying run once. A scan ends on window completion, abort or
// input-starvation timeout, and the end is reported with a one-cycle done.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, abort          begin scan (IDLE only), terminate scan (RUN only)
//   cfg_len, cfg_mode     run length (0/1 treated as 2), polarity select
//   w_valid, w            serial bit stream with qualifier
//   s                     run flag, updated the cycle after each accepted bit
//   busy, done            scan in progress, one-cycle completion pulse
//   timed_out, aborted    how the last scan ended
//   match_cnt             saturating count of qualifying runs
module run_detect_ctrl #(
    parameter int unsigned WINDOW  = 64,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       cfg_len,
    input  logic [1:0]       cfg_mode,
    input  logic             w_valid,
    input  logic             w,
    output logic             s,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned BIT_W  = $clog2(WINDOW + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [3:0]        len_q, len_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [3:0]        run_cnt, run_cnt_nxt;
    logic              last_bit, last_bit_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic              win_end, win_end_nxt;
    logic              s_nxt, busy_nxt, done_nxt, timed_out_nxt, aborted_nxt;
    logic [CNT_W-1:0]  match_cnt_nxt;

    logic [3:0]        run_upd;
    logic              pol_en;
    logic [BIT_W-1:0]  bit_inc;
    logic [IDLE_W-1:0] idle_inc;
    logic [3:0]        len_clamp;
    logic              cnt_full;

    // Run length after accepting w: extend (saturating at 15) or restart at 1
    assign run_upd   = ((run_cnt == 4'd0) || (w == last_bit))
                       ? ((run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1)
                       : 4'd1;
    assign pol_en    = (mode_q == 2'b00) || (w ? mode_q[1] : mode_q[0]);
    assign bit_inc   = bit_cnt + BIT_W'(1);
    assign idle_inc  = idle_cnt + IDLE_W'(1);
    assign len_clamp = (cfg_len < 4'd2) ? 4'd2 : cfg_len;
    assign cnt_full  = (match_cnt == {CNT_W{1'b1}});

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        mode_nxt      = mode_q;
        run_cnt_nxt   = run_cnt;
        last_bit_nxt  = last_bit;
        bit_cnt_nxt   = bit_cnt;
        idle_cnt_nxt  = idle_cnt;
        win_end_nxt   = win_end;
        s_nxt         = s;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        timed_out_nxt = timed_out;
        aborted_nxt   = aborted;
        match_cnt_nxt = match_cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_nxt       = len_clamp;
                    mode_nxt      = cfg_mode;
                    run_cnt_nxt   = 4'd0;
                    bit_cnt_nxt   = '0;
                    idle_cnt_nxt  = '0;
                    win_end_nxt   = 1'b0;
                    match_cnt_nxt = '0;
                    timed_out_nxt = 1'b0;
                    aborted_nxt   = 1'b0;
                    busy_nxt      = 1'b1;
                    state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                // Window finished last cycle: s for the final bit has been
                // visible for one cycle, now close the scan.
                if (win_end) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    s_nxt     = 1'b0;
                end else if (abort) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    s_nxt       = 1'b0;
                end else if (w_valid) begin
                    bit_cnt_nxt  = bit_inc;
                    idle_cnt_nxt = '0;
                    run_cnt_nxt  = run_upd;
                    last_bit_nxt = w;
                    s_nxt        = pol_en && (run_upd >= len_q);
                    // Count only on the transition into len, not while a
                    // saturated run sits at len == 15.
                    if (pol_en && (run_upd == len_q) && (run_upd != run_cnt) && !cnt_full)
                        match_cnt_nxt = match_cnt + CNT_W'(1);
                    if (bit_inc == BIT_W'(WINDOW))
                        win_end_nxt = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_inc;
                    if (idle_inc == IDLE_W'(TIMEOUT)) begin
                        timed_out_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                        busy_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                        s_nxt         = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                s_nxt     = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= 4'd0;
            mode_q    <= 2'd0;
            run_cnt   <= 4'd0;
            last_bit  <= 1'b0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            win_end   <= 1'b0;
            s         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            aborted   <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            mode_q    <= mode_nxt;
            run_cnt   <= run_cnt_nxt;
            last_bit  <= last_bit_nxt;
            bit_cnt   <= bit_cnt_nxt;
            idle_cnt  <= idle_cnt_nxt;
            win_end   <= win_end_nxt;
            s         <= s_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            timed_out <= timed_out_nxt;
            aborted   <= aborted_nxt;
            match_cnt <= match_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Testbench for run_detect_ctrl: a cycle model predicts the full status
// vector for every driven cycle and queues it; the DUT value is popped and
// compared just after the clock edge.
module tb_run_detect_ctrl;

    localparam int unsigned WIN = 12;
    localparam int unsigned TO  = 32;
    localparam int unsigned CW  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    cfg_len = 4'd0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          w_valid = 1'b0;
    logic          w = 1'b0;
    logic          s, busy, done, timed_out, aborted;
    logic [CW-1:0] match_cnt;

    run_detect_ctrl #(.WINDOW(WIN), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .cfg_mode  (cfg_mode),
        .w_valid   (w_valid),
        .w         (w),
        .s         (s),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out),
        .aborted   (aborted),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // {busy, done, s, timed_out, aborted, match_cnt}
    logic [12:0] exp_q[$];

    // Reference model state
    int         m_state = 0;   // 0 idle, 1 run, 2 done
    int         m_run   = 0;   // unbounded run length
    int         m_bits  = 0;
    int         m_idle  = 0;
    int         m_cnt   = 0;
    int         m_len   = 0;
    logic [1:0] m_mode  = 2'd0;
    logic       m_last  = 1'b0;
    logic       m_pend  = 1'b0;
    logic       m_s = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_to = 1'b0, m_ab = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_end();
        m_state = 2;
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_s     = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic st, input logic ab,
                              input logic wv, input logic wb);
        logic en;
        if (rst) begin
            m_state = 0; m_run = 0; m_bits = 0; m_idle = 0; m_cnt = 0;
            m_len = 0; m_mode = 2'd0; m_last = 1'b0; m_pend = 1'b0;
            m_s = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_to = 1'b0; m_ab = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_state == 0) begin
                if (st) begin
                    m_len  = (int'(cfg_len) < 2) ? 2 : int'(cfg_len);
                    m_mode = cfg_mode;
                    m_run = 0; m_bits = 0; m_idle = 0; m_cnt = 0;
                    m_to = 1'b0; m_ab = 1'b0; m_pend = 1'b0;
                    m_busy = 1'b1;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (m_pend) begin
                    model_end();
                end else if (ab) begin
                    m_ab = 1'b1;
                    model_end();
                end else if (wv) begin
                    m_bits++;
                    m_idle = 0;
                    if (m_run == 0 || wb == m_last) m_run++;
                    else m_run = 1;
                    m_last = wb;
                    en = (m_mode == 2'b00) || (wb ? m_mode[1] : m_mode[0]);
                    m_s = en && (m_run >= m_len);
                    if (en && m_run == m_len && m_cnt < 255) m_cnt++;
                    if (m_bits == int'(WIN)) m_pend = 1'b1;
                end else begin
                    m_idle++;
                    if (m_idle == int'(TO)) begin
                        m_to = 1'b1;
                        model_end();
                    end
                end
            end else begin
                m_state = 0;
            end
        end
        exp_q.push_back({m_busy, m_done, m_s, m_to, m_ab, 8'(m_cnt)});
    endtask

    // Drive one cycle, predict, then compare after the edge
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic ab, input logic wv, input logic wb);
        logic [12:0] e;
        @(negedge clk);
        reset = rst; start = st; abort = ab; w_valid = wv; w = wb;
        model_step(rst, st, ab, wv, wb);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq(tag, 32'({busy, done, s, timed_out, aborted, match_cnt}), 32'(e));
    endtask

    task automatic feed(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b0, 1'b0, 1'b0, 1'b1, bits[i]);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles("idle", 2);
        check_eq("reset_busy", 32'(busy), 32'd0);

        // len 4, both polarities: 1111 0000
        cfg_len = 4'd4; cfg_mode = 2'b11;
        step("t1_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        feed("t1_bit", 32'b1111_0000, 8);
        check_eq("t1_match_cnt", 32'(match_cnt), 32'd2);
        check_eq("t1_s_after_bit8", 32'(s), 32'd1);
        step("t1_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles("t1_idle", 2);

        // len 4, zero-runs only: 111111 00000
        cfg_len = 4'd4; cfg_mode = 2'b01;
        step("t2_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed("t2_bit", 32'b111111_00000, 11);
        check_eq("t2_match_cnt", 32'(match_cnt), 32'd1);
        step("t2_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles("t2_idle", 1);

        // Window end with alternating bits; start in DONE is ignored
        cfg_len = 4'd2; cfg_mode = 2'b11;
        step("t3_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed("t3_bit", 32'b0101_0101_0101, 12);
        check_eq("t3_busy_after_last", 32'(busy), 32'd1);
        step("t3_close", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_done", 32'(done), 32'd1);
        step("t3_start_in_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles("t3_idle", 2);
        check_eq("t3_timed_out", 32'(timed_out), 32'd0);
        check_eq("t3_match_cnt", 32'(match_cnt), 32'd0);

        // Starvation timeout
        cfg_len = 4'd4; cfg_mode = 2'b11;
        step("t4_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed("t4_bit", 32'b10, 2);
        idle_cycles("t4_starve", int'(TO) + 6);
        check_eq("t4_timed_out", 32'(timed_out), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);

        // Abort together with a valid bit that would complete the run
        cfg_len = 4'd3; cfg_mode = 2'b10;
        step("t5_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed("t5_bit", 32'b11, 2);
        step("t5_abort_valid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t5_aborted", 32'(aborted), 32'd1);
        check_eq("t5_match_cnt", 32'(match_cnt), 32'd0);
        idle_cycles("t5_idle", 2);

        // len 0 acts as 2; start while busy ignored; reset mid-scan
        cfg_len = 4'd0; cfg_mode = 2'b00;
        step("t6_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        feed("t6_bit", 32'b00, 2);
        check_eq("t6_len0_s", 32'(s), 32'd1);
        cfg_len = 4'd9;
        step("t6_start_busy", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t6_match_cnt", 32'(match_cnt), 32'd1);
        step("t6_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles("t6_after_reset", 3);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
